ps2_kbd: RTL and testbench

PS/2 keyboard front end that produces the 16-bit Hack `kbd` word consumed by the computer's keyboard memory-map input.
- Receives PS/2 set-2 scancode frames.
- Tracks make/break and E0-extended prefixes.
- Translates keys to Hack key codes.
- Holds the code while the key is pressed; returns 0 on release.
- Sits between the board PS/2 pins and the computer's `kbd` input.

---
 rtl/hack_kbd_pkg.sv | 36 +++
 rtl/ps2_scancode_map.sv | 74 +++++++
 rtl/ps2_kbd.sv | 172 +++++++++++++++++
 tb/tb_ps2_kbd.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_kbd_pkg.sv
// Shared constants for the PS/2 keyboard front end: Hack key codes,
// PS/2 prefix bytes and the frame receiver state encoding.
package hack_kbd_pkg;

  localparam logic [15:0] KEY_NEWLINE   = 16'd128;
  localparam logic [15:0] KEY_BACKSPACE = 16'd129;
  localparam logic [15:0] KEY_LEFT      = 16'd130;
  localparam logic [15:0] KEY_UP        = 16'd131;
  localparam logic [15:0] KEY_RIGHT     = 16'd132;
  localparam logic [15:0] KEY_DOWN      = 16'd133;
  localparam logic [15:0] KEY_HOME      = 16'd134;
  localparam logic [15:0] KEY_END       = 16'd135;
  localparam logic [15:0] KEY_PGUP      = 16'd136;
  localparam logic [15:0] KEY_PGDN      = 16'd137;
  localparam logic [15:0] KEY_INSERT    = 16'd138;
  localparam logic [15:0] KEY_DELETE    = 16'd139;
  localparam logic [15:0] KEY_ESC       = 16'd140;
  localparam logic [15:0] KEY_F1        = 16'd141;
  localparam logic [15:0] KEY_F2        = 16'd142;
  localparam logic [15:0] KEY_F3        = 16'd143;
  localparam logic [15:0] KEY_F4        = 16'd144;
  localparam logic [15:0] KEY_F5        = 16'd145;
  localparam logic [15:0] KEY_F6        = 16'd146;
  localparam logic [15:0] KEY_F7        = 16'd147;
  localparam logic [15:0] KEY_F8        = 16'd148;
  localparam logic [15:0] KEY_F9        = 16'd149;
  localparam logic [15:0] KEY_F10       = 16'd150;
  localparam logic [15:0] KEY_F11       = 16'd151;
  localparam logic [15:0] KEY_F12       = 16'd152;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;

endpackage

// File: rtl/ps2_scancode_map.sv
// Set-2 scancode to Hack key code translation (combinational).
// PS2_SHIFT_EN: letters become lowercase unless shift is held.
module ps2_scancode_map
  import hack_kbd_pkg::*;
(
  input  logic [7:0]  scancode,
  input  logic        ext,
  input  logic        shift,
  output logic [15:0] key_code
);

  logic [7:0] letter;

`ifndef PS2_SHIFT_EN
  logic unused_shift;
  assign unused_shift = shift;
`endif

  always_comb begin
    letter   = 8'h00;
    key_code = 16'h0000;
    if (ext) begin
      case (scancode)
        8'h6B: key_code = KEY_LEFT;
        8'h75: key_code = KEY_UP;
        8'h74: key_code = KEY_RIGHT;
        8'h72: key_code = KEY_DOWN;
        8'h6C: key_code = KEY_HOME;
        8'h69: key_code = KEY_END;
        8'h7D: key_code = KEY_PGUP;
        8'h7A: key_code = KEY_PGDN;
        8'h70: key_code = KEY_INSERT;
        8'h71: key_code = KEY_DELETE;
        default: key_code = 16'h0000;
      endcase
    end else begin
      case (scancode)
        8'h1C: letter = 8'h41;  8'h32: letter = 8'h42;  8'h21: letter = 8'h43;
        8'h23: letter = 8'h44;  8'h24: letter = 8'h45;  8'h2B: letter = 8'h46;
        8'h34: letter = 8'h47;  8'h33: letter = 8'h48;  8'h43: letter = 8'h49;
        8'h3B: letter = 8'h4A;  8'h42: letter = 8'h4B;  8'h4B: letter = 8'h4C;
        8'h3A: letter = 8'h4D;  8'h31: letter = 8'h4E;  8'h44: letter = 8'h4F;
        8'h4D: letter = 8'h50;  8'h15: letter = 8'h51;  8'h2D: letter = 8'h52;
        8'h1B: letter = 8'h53;  8'h2C: letter = 8'h54;  8'h3C: letter = 8'h55;
        8'h2A: letter = 8'h56;  8'h1D: letter = 8'h57;  8'h22: letter = 8'h58;
        8'h35: letter = 8'h59;  8'h1A: letter = 8'h5A;
        8'h45: key_code = 16'h0030;  8'h16: key_code = 16'h0031;
        8'h1E: key_code = 16'h0032;  8'h26: key_code = 16'h0033;
        8'h25: key_code = 16'h0034;  8'h2E: key_code = 16'h0035;
        8'h36: key_code = 16'h0036;  8'h3D: key_code = 16'h0037;
        8'h3E: key_code = 16'h0038;  8'h46: key_code = 16'h0039;
        8'h29: key_code = 16'h0020;
        8'h5A: key_code = KEY_NEWLINE;
        8'h66: key_code = KEY_BACKSPACE;
        8'h76: key_code = KEY_ESC;
        8'h05: key_code = KEY_F1;   8'h06: key_code = KEY_F2;
        8'h04: key_code = KEY_F3;   8'h0C: key_code = KEY_F4;
        8'h03: key_code = KEY_F5;   8'h0B: key_code = KEY_F6;
        8'h83: key_code = KEY_F7;   8'h0A: key_code = KEY_F8;
        8'h01: key_code = KEY_F9;   8'h09: key_code = KEY_F10;
        8'h78: key_code = KEY_F11;  8'h07: key_code = KEY_F12;
        default: key_code = 16'h0000;
      endcase
      if (letter != 8'h00) begin
`ifdef PS2_SHIFT_EN
        key_code = {8'h00, shift ? letter : (letter | 8'h20)};
`else
        key_code = {8'h00, letter};
`endif
      end
    end
  end

endmodule

// File: rtl/ps2_kbd.sv
// PS/2 keyboard receiver producing the Hack kbd word (held key code, 0 on release).
// PS2_SHIFT_EN: track shift keys and emit lowercase letters unless shift is held.
//
// frame state | meaning
// IDLE        | waiting for a start bit (strobe with data low)
// DATA        | shifting in 8 data bits, LSB first
// PARITY      | capturing the odd-parity bit
// STOP        | checking stop bit and parity, then byte_done or frame_err
module ps2_kbd
  import hack_kbd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 12000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] kbd,
  output logic        key_valid,
  output logic        frame_err
);

  localparam int unsigned FILT_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES);
  // Reload is two short so frame_err lands exactly TIMEOUT_CYCLES after the strobe cycle.
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 2);

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   filt_clk;
  logic [FILT_W-1:0]      filt_cnt;
  logic                   strobe, data_bit;

  frame_state_t           state;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;
  logic                   par;
  logic [TMO_W-1:0]       tmo_cnt;
  logic                   byte_done;

  logic                   ext, brk, shift_held;
  logic [15:0]            key_code;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      filt_clk  <= 1'b1;
      filt_cnt  <= '0;
      strobe    <= 1'b0;
      data_bit  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      strobe    <= 1'b0;
      if (clk_sync[SYNC_STAGES-1] != filt_clk) begin
        if (filt_cnt == FILT_W'(FILTER_LEN - 1)) begin
          filt_clk <= clk_sync[SYNC_STAGES-1];
          filt_cnt <= '0;
          strobe   <= filt_clk;
          data_bit <= data_sync[SYNC_STAGES-1];
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      tmo_cnt   <= '0;
      byte_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      frame_err <= 1'b0;
      if (strobe) tmo_cnt <= TMO_LOAD;
      else if (state != IDLE) tmo_cnt <= tmo_cnt - 1'b1;
      case (state)
        IDLE: if (strobe && !data_bit) begin
          state   <= DATA;
          bit_cnt <= '0;
        end
        DATA: if (strobe) begin
          shreg   <= {data_bit, shreg[7:1]};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state <= PARITY;
        end
        PARITY: if (strobe) begin
          par   <= data_bit;
          state <= STOP;
        end
        STOP: if (strobe) begin
          if (data_bit && (^{shreg, par})) byte_done <= 1'b1;
          else frame_err <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (state != IDLE && !strobe && tmo_cnt == '0) begin
        frame_err <= 1'b1;
        state     <= IDLE;
      end
    end
  end

  ps2_scancode_map u_map (
    .scancode (shreg),
    .ext      (ext),
    .shift    (shift_held),
    .key_code (key_code)
  );

`ifdef PS2_SHIFT_EN
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;

  always_ff @(posedge clk) begin
    if (reset) shift_held <= 1'b0;
    else if (byte_done && (shreg == PS2_LSHIFT || shreg == PS2_RSHIFT)) shift_held <= !brk;
  end

  logic is_shift;
  assign is_shift = (shreg == PS2_LSHIFT) || (shreg == PS2_RSHIFT);
`else
  logic is_shift;
  assign shift_held = 1'b0;
  assign is_shift   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      kbd       <= '0;
      key_valid <= 1'b0;
      ext       <= 1'b0;
      brk       <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_done) begin
        if (shreg == PS2_EXT) begin
          ext <= 1'b1;
        end else if (shreg == PS2_BRK) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (!is_shift) begin
            if (!brk) begin
              if (key_code != 16'h0000) begin
                kbd       <= key_code;
                key_valid <= 1'b1;
              end
            end else if (key_code == kbd) begin
              kbd <= '0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_kbd.sv
// Self-checking bench for ps2_kbd: directed scenarios plus a randomized
// byte stream checked against a table-driven key model.
module tb_ps2_kbd;

  localparam int SYNC_STAGES    = 2;
  localparam int FILTER_LEN     = 4;
  localparam int TIMEOUT_CYCLES = 12000;
  localparam int HALF           = 16;
  localparam int GAP            = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] kbd;
  logic        key_valid;
  logic        frame_err;

  ps2_kbd #(
    .SYNC_STAGES    (SYNC_STAGES),
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .kbd       (kbd),
    .key_valid (key_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int fails = 0;

  int   cyc = 0, kv_cnt = 0, kv_long = 0, fe_cnt = 0, fe_long = 0;
  int   last_strobe_cyc = 0, fe_cyc = 0;
  logic kv_prev = 1'b0, fe_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (key_valid) begin
      kv_cnt++;
      if (kv_prev) kv_long++;
    end
    if (frame_err) begin
      fe_cnt++;
      if (fe_prev) fe_long++;
      else fe_cyc = cyc;
    end
    kv_prev = key_valid;
    fe_prev = frame_err;
    if (dut.strobe) last_strobe_cyc = cyc;
  end

  // Reference scancode tables; index i maps to base code + i.
  logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_sc  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] nav_sc    [10] = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D, 8'h7A, 8'h70, 8'h71};
  logic [7:0] fkey_sc   [12] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01, 8'h09, 8'h78, 8'h07};
  logic [7:0] pool      [24] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h45, 8'h16, 8'h29, 8'h5A, 8'h66, 8'h76,
                                 8'h05, 8'h07, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'h75, 8'h6B, 8'h71,
                                 8'h12, 8'h59, 8'h0E, 8'h61};

  logic [15:0] m_kbd;
  logic        m_ext, m_brk;
  int          m_kv;
`ifdef PS2_SHIFT_EN
  logic        m_shift;
`endif

  function automatic logic [15:0] ref_map(input logic [7:0] sc, input logic e);
    logic [15:0] r;
    r = 16'h0;
    if (e) begin
      for (int i = 0; i < 10; i++) if (sc == nav_sc[i]) r = 16'(130 + i);
    end else begin
      for (int i = 0; i < 26; i++) begin
        if (sc == letter_sc[i]) begin
`ifdef PS2_SHIFT_EN
          r = m_shift ? 16'(8'h41 + i) : 16'(8'h61 + i);
`else
          r = 16'(8'h41 + i);
`endif
        end
      end
      for (int i = 0; i < 10; i++) if (sc == digit_sc[i]) r = 16'(8'h30 + i);
      for (int i = 0; i < 12; i++) if (sc == fkey_sc[i]) r = 16'(141 + i);
      if (sc == 8'h29) r = 16'h0020;
      if (sc == 8'h5A) r = 16'd128;
      if (sc == 8'h66) r = 16'd129;
      if (sc == 8'h76) r = 16'd140;
    end
    return r;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    logic [15:0] code;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
`ifdef PS2_SHIFT_EN
      if (b == 8'h12 || b == 8'h59) m_shift = !m_brk;
      else begin
`else
      begin
`endif
        code = ref_map(b, m_ext);
        if (!m_brk) begin
          if (code != 16'h0) begin
            m_kbd = code;
            m_kv++;
          end
        end else if (code == m_kbd) m_kbd = 16'h0;
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic ps2_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) ps2_data = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    logic p;
    p = (~^b) ^ bad_par;
    ps2_bits({1'b1, p, b, 1'b0}, 11);
    ps2_data = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (kbd !== 16'h0) begin fails++; $display("FAIL reset_kbd got=%h want=0000", kbd); end
    tests_run++;
    if (key_valid !== 1'b0) begin fails++; $display("FAIL reset_key_valid got=%b want=0", key_valid); end
    tests_run++;
    if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
  endtask

  task automatic test_make_break();
    logic [7:0]  seq [3]  = '{8'h1C, 8'hF0, 8'h1C};
    logic [15:0] want [3] = '{16'h0041, 16'h0041, 16'h0000};
    int          kv_w [3] = '{1, 0, 0};
    int kv0, kl0;
    kl0 = kv_long;
    for (int i = 0; i < 3; i++) begin
      kv0 = kv_cnt;
      send_frame(seq[i], 1'b0);
      tests_run++;
      if (kbd !== want[i]) begin fails++; $display("FAIL make_break_kbd step=%0d got=%h want=%h", i, kbd, want[i]); end
      tests_run++;
      if (kv_cnt - kv0 != kv_w[i]) begin fails++; $display("FAIL make_break_kv step=%0d got=%0d want=%0d", i, kv_cnt - kv0, kv_w[i]); end
    end
    tests_run++;
    if (kv_long != kl0) begin fails++; $display("FAIL key_valid_width extra_cycles=%0d want=0", kv_long - kl0); end
  endtask

  task automatic test_extended();
    logic [7:0]  seq [6]  = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h5A};
    logic [15:0] want [6] = '{16'h0000, 16'h0083, 16'h0083, 16'h0083, 16'h0000, 16'h0080};
    for (int i = 0; i < 6; i++) begin
      send_frame(seq[i], 1'b0);
      tests_run++;
      if (kbd !== want[i]) begin fails++; $display("FAIL extended_kbd step=%0d got=%h want=%h", i, kbd, want[i]); end
    end
    send_frame(8'hF0, 1'b0);
    send_frame(8'h5A, 1'b0);
  endtask

  task automatic test_overlap();
    logic [7:0]  seq [6]  = '{8'h1C, 8'h32, 8'hF0, 8'h1C, 8'hF0, 8'h32};
    logic [15:0] want [6] = '{16'h0041, 16'h0042, 16'h0042, 16'h0042, 16'h0042, 16'h0000};
    for (int i = 0; i < 6; i++) begin
      send_frame(seq[i], 1'b0);
      tests_run++;
      if (kbd !== want[i]) begin fails++; $display("FAIL overlap_kbd step=%0d got=%h want=%h", i, kbd, want[i]); end
    end
  endtask

  task automatic test_repeat();
    int kv0;
    send_frame(8'h1C, 1'b0);
    kv0 = kv_cnt;
    send_frame(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0);
    tests_run++;
    if (kv_cnt - kv0 != 2) begin fails++; $display("FAIL repeat_kv got=%0d want=2", kv_cnt - kv0); end
    tests_run++;
    if (kbd !== 16'h0041) begin fails++; $display("FAIL repeat_kbd got=%h want=0041", kbd); end
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
  endtask

  task automatic test_parity_err();
    int fe0, kv0, fl0;
    fe0 = fe_cnt; kv0 = kv_cnt; fl0 = fe_long;
    send_frame(8'h1C, 1'b1);
    tests_run++;
    if (fe_cnt - fe0 != 1) begin fails++; $display("FAIL parity_err_pulses got=%0d want=1", fe_cnt - fe0); end
    tests_run++;
    if (fe_long != fl0) begin fails++; $display("FAIL parity_err_width extra_cycles=%0d want=0", fe_long - fl0); end
    tests_run++;
    if (kbd !== 16'h0 || kv_cnt != kv0) begin fails++; $display("FAIL parity_err_kbd got=%h kv=%0d want=0000 kv=0", kbd, kv_cnt - kv0); end
    send_frame(8'h16, 1'b0);
    tests_run++;
    if (kbd !== 16'h0031) begin fails++; $display("FAIL after_parity_kbd got=%h want=0031", kbd); end
    send_frame(8'hF0, 1'b0);
    send_frame(8'h16, 1'b0);
  endtask

  task automatic test_timeout();
    int  fe0;
    bit  seen;
    fe0 = fe_cnt;
    seen = 0;
    ps2_bits({1'b1, 1'b0, 8'hA5, 1'b0}, 6);
    ps2_data = 1'b1;
    for (int i = 0; i < TIMEOUT_CYCLES + 1000 && !seen; i++) begin
      @(negedge clk);
      if (fe_cnt != fe0) seen = 1;
    end
    tests_run++;
    if (!seen) begin
      fails++; $display("FAIL timeout_seen got=none want=frame_err within %0d cycles", TIMEOUT_CYCLES + 1000);
    end else begin
      tests_run++;
      if (fe_cyc - last_strobe_cyc != TIMEOUT_CYCLES) begin
        fails++; $display("FAIL timeout_delay got=%0d want=%0d", fe_cyc - last_strobe_cyc, TIMEOUT_CYCLES);
      end
    end
    repeat (GAP) @(negedge clk);
    send_frame(8'h29, 1'b0);
    tests_run++;
    if (kbd !== 16'h0020) begin fails++; $display("FAIL after_timeout_kbd got=%h want=0020", kbd); end
    send_frame(8'hF0, 1'b0);
    send_frame(8'h29, 1'b0);
  endtask

  task automatic test_reset_midframe();
    int fe0;
    send_frame(8'h1C, 1'b0);
    tests_run++;
    if (kbd !== 16'h0041) begin fails++; $display("FAIL pre_reset_kbd got=%h want=0041", kbd); end
    ps2_bits({1'b1, 1'b0, 8'h2A, 1'b0}, 4);
    ps2_data = 1'b1;
    fe0 = fe_cnt;
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (kbd !== 16'h0) begin fails++; $display("FAIL reset_midframe_kbd got=%h want=0000", kbd); end
    reset = 1'b0;
    repeat (TIMEOUT_CYCLES + 200) @(negedge clk);
    tests_run++;
    if (fe_cnt != fe0) begin fails++; $display("FAIL reset_midframe_err pulses=%0d want=0", fe_cnt - fe0); end
    send_frame(8'h76, 1'b0);
    tests_run++;
    if (kbd !== 16'h008C) begin fails++; $display("FAIL esc_kbd got=%h want=008c", kbd); end
    send_frame(8'hF0, 1'b0);
    send_frame(8'h76, 1'b0);
  endtask

  task automatic test_shift();
`ifdef PS2_SHIFT_EN
    send_frame(8'h12, 1'b0);
    tests_run++;
    if (kbd !== 16'h0) begin fails++; $display("FAIL shift_no_drive got=%h want=0000", kbd); end
    send_frame(8'h1C, 1'b0);
    tests_run++;
    if (kbd !== 16'h0041) begin fails++; $display("FAIL shift_upper got=%h want=0041", kbd); end
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h12, 1'b0);
    send_frame(8'h1C, 1'b0);
    tests_run++;
    if (kbd !== 16'h0061) begin fails++; $display("FAIL shift_lower got=%h want=0061", kbd); end
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
`else
    int kv0;
    kv0 = kv_cnt;
    send_frame(8'h12, 1'b0);
    tests_run++;
    if (kbd !== 16'h0 || kv_cnt != kv0) begin fails++; $display("FAIL unmapped_shift got=%h kv=%0d want=0000 kv=0", kbd, kv_cnt - kv0); end
    send_frame(8'hF0, 1'b0);
    send_frame(8'h12, 1'b0);
`endif
  endtask

  task automatic test_random();
    logic [7:0] b;
    int kv_base;
    do_reset();
    m_kbd = 16'h0; m_ext = 1'b0; m_brk = 1'b0; m_kv = 0;
`ifdef PS2_SHIFT_EN
    m_shift = 1'b0;
`endif
    kv_base = kv_cnt;
    for (int i = 0; i < 32; i++) begin
      b = pool[$urandom_range(0, 23)];
      model_byte(b);
      send_frame(b, 1'b0);
      tests_run++;
      if (kbd !== m_kbd || kv_cnt - kv_base != m_kv) begin
        fails++;
        $display("FAIL random step=%0d byte=%h kbd=%h want=%h kv=%0d want=%0d", i, b, kbd, m_kbd, kv_cnt - kv_base, m_kv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_overlap();
    test_repeat();
    test_parity_err();
    test_timeout();
    test_reset_midframe();
    test_shift();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog simulation exceeded 150000 cycles");
    $fatal(1);
  end

endmodule
